// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - state encoding and key constant shared by the game flow logic
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam logic [7:0] START_KEY = 8'h2C;

endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - 4-digit BCD counter with clear and increment saturating at 9999
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] value_inc;
    logic        carry;

    // Ripple the carry through the digits; a 9 rolls to 0 and passes the carry on.
    always_comb begin
        value_inc = value;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] == 4'd9) begin
                    value_inc[i*4 +: 4] = 4'd0;
                end else begin
                    value_inc[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 16'h0000;
        end else if (clr) begin
            value <= 16'h0000;
        end else if (inc && (value != 16'h9999)) begin
            value <= value_inc;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - title/play/hit/over flow, lives, score and high score from the collision lose flag
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int HIT_FRAMES   = 2,
    parameter int FLASH_FRAMES = 60,
    parameter int SCORE_DIV    = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        L,
    input  logic [7:0]  keycode,
    output logic [1:0]  game_state,
    output logic        play_en,
    output logic        round_reset,
    output logic        flash,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [3:0] HIT_LAST   = 4'(HIT_FRAMES - 1);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] DIV_LAST   = 8'(SCORE_DIV - 1);

    logic       sync1, sync2, sync3, frame_tick;
    logic       key_up;
    logic       start;
    state_t     state_q, state_d;
    logic [3:0] hit_q, hit_d;
    logic [7:0] div_q, div_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;
    logic [1:0] lives_d;
    logic [15:0] high_score_d;
    logic       round_reset_d;
    logic       score_clr, score_inc;

    // key_up resets to 0 so a key held through reset must be released before it can start a game.
    assign start      = (keycode == START_KEY) && key_up;
    assign game_state = state_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            frame_tick <= 1'b0;
            key_up     <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            sync3      <= sync2;
            frame_tick <= sync2 && !sync3;
            key_up     <= (keycode != START_KEY);
        end
    end

    always_comb begin
        state_d       = state_q;
        hit_d         = hit_q;
        div_d         = div_q;
        flash_cnt_d   = flash_cnt_q;
        lives_d       = lives;
        high_score_d  = high_score;
        round_reset_d = 1'b0;
        score_clr     = 1'b0;
        score_inc     = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d       = ST_PLAY;
                    lives_d       = LIVES_INIT;
                    hit_d         = 4'd0;
                    div_d         = 8'd0;
                    score_clr     = 1'b1;
                    round_reset_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (L && (hit_q == HIT_LAST)) begin
                        // A hit pre-empts any score point due on this tick; div_cnt holds.
                        hit_d   = 4'd0;
                        lives_d = lives - 2'd1;
                        if (lives == 2'd1) begin
                            state_d = ST_OVER;
                            if (score > high_score) begin
                                high_score_d = score;
                            end
                        end else begin
                            state_d     = ST_HIT;
                            flash_cnt_d = 8'd0;
                        end
                    end else begin
                        hit_d = L ? hit_q + 4'd1 : 4'd0;
                        if (div_q == DIV_LAST) begin
                            div_d     = 8'd0;
                            score_inc = 1'b1;
                        end else begin
                            div_d = div_q + 8'd1;
                        end
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        state_d       = ST_PLAY;
                        round_reset_d = 1'b1;
                        hit_d         = 4'd0;
                        div_d         = 8'd0;
                        flash_cnt_d   = 8'd0;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            hit_q       <= 4'd0;
            div_q       <= 8'd0;
            flash_cnt_q <= 8'd0;
            lives       <= 2'd0;
            high_score  <= 16'h0000;
            round_reset <= 1'b0;
            play_en     <= 1'b0;
            flash       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            div_q       <= div_d;
            flash_cnt_q <= flash_cnt_d;
            lives       <= lives_d;
            high_score  <= high_score_d;
            round_reset <= round_reset_d;
            play_en     <= (state_d == ST_PLAY);
            flash       <= (state_d == ST_HIT) && flash_cnt_d[3];
        end
    end

    bcd_counter4 u_score (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clr   (score_clr),
        .inc   (score_inc),
        .value (score)
    );

endmodule
